gate_sweep: RTL
===============

# gate_sweep

Parametrised exhaustive truth-table checker for N-input logic gates, run as a self-checking harness beside a gate under test. On `start` it drives every input combination 0 … 2^N_IN−1 onto `stim` in order. After a programmable settle time it samples the gate's response and compares it with an internal reference for the selected function, counting mismatches. It generalises the two-input, fixed-function, four-vector gate check into a clocked block with selectable gate function, input count and settle delay.

## Interface
- `N_IN`, default 2: gate input count, legal 1..8.
- `SETTLE`, default 1: wait cycles between driving `stim` and sampling `dut_op`, legal 0..15.
- `CNT_W`, default 8: width of the mismatch counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `op` in 3: function select. 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR; 110 and 111 are reserved.
- `dut_op` in 1: response of the gate under test.
- `stim` out N_IN: current input vector to the gate under test.
- `busy` out 1: high from the cycle after an accepted start until DONE.
- `done` out 1: one-cycle pulse at sweep end.
- `pass` out 1: high when the last completed sweep had zero mismatches.
- `err_cnt` out CNT_W: mismatch count; saturates at all-ones.
- `op_err` out 1: one-cycle pulse when `start` arrives with a reserved `op`.
- `first_fail` out N_IN: `stim` value at the first mismatch.
- `fail_valid` out 1: `first_fail` holds a captured value.

## Operation
- Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `op_err`=0, `first_fail`=0, `fail_valid`=0. The FSM returns to IDLE.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, `start` with a valid `op`:
  - Latch `op`.
  - Clear `stim`, `err_cnt`, `pass`, `first_fail` and `fail_valid`.
  - Go to SETTLE, or directly to CHECK when SETTLE=0.
- IDLE, `start` with a reserved `op`: pulse `op_err` next cycle and stay in IDLE; outputs are otherwise untouched.
- SETTLE: count SETTLE cycles, then go to CHECK.
- CHECK:
  - Reference: AND = &stim, OR = |stim, XOR = ^stim; NAND, NOR and XNOR are their inversions.
  - If `dut_op` ≠ reference, increment `err_cnt` with saturation. If `fail_valid`=0, load `first_fail`=`stim` and set `fail_valid`.
  - If `stim` is all-ones, go to DONE. Otherwise increment `stim` and go to SETTLE (or stay in CHECK when SETTLE=0).
- DONE:
  - Pulse `done` and set `pass`=(`err_cnt`==0), including the final CHECK's result.
  - Drop `busy` and return to IDLE.
  - `stim` holds all-ones until the next start.
- `start` while not in IDLE is ignored, including in the DONE cycle.
- `op` changes during a sweep have no effect; the latched copy is used.
- Saturation: once `err_cnt` is all-ones it stays there, and `pass` stays 0.
- Reset asserted mid-sweep: immediate return to reset values; no `done` pulse. A new `start` after reset release runs a full fresh sweep.

## Timing
- `start` is sampled at edge 0. `busy`=1 and `stim`=0 are visible after edge 0.
- Each vector occupies SETTLE+1 cycles, so `stim` changes every SETTLE+1 cycles.
- `dut_op` is sampled on the CHECK edge. The gate path must settle within SETTLE+1 cycles.
- `done` is high for the single cycle after the final CHECK edge. Start-to-done latency is 2^N_IN·(SETTLE+1)+1 cycles.
- `pass`, `err_cnt` and `first_fail` are valid when `done`=1 and hold until the next accepted start.
- Back-to-back sweeps: the earliest accepted `start` is the cycle after `done`.

## Configuration
- `GATE_SWEEP_FAIL_CAPTURE_EN` defined: `first_fail` and `fail_valid` behave as described under Operation.
- Not defined: `first_fail` and `fail_valid` are tied to 0 and the capture register is removed. All other behaviour is unchanged.

## Test plan
- OR with a correct OR gate, N_IN=2, SETTLE=1:
  - `stim` sequence 00, 01, 10, 11.
  - `done` exactly 9 cycles after start.
  - `err_cnt`=0, `pass`=1, `fail_valid`=0.
- OR with `dut_op` stuck at 0: `err_cnt`=3, `pass`=0, `first_fail`=2'b01, `fail_valid`=1.
- NAND selected against a correct OR gate: mismatches at 00 and 11, so `err_cnt`=2 and `first_fail`=2'b00.
- N_IN=3, SETTLE=0, CNT_W=1, XOR with inverted `dut_op`:
  - 8 mismatches, `err_cnt` saturated at 1.
  - `done` 9 cycles after start.
- `start` with `op`=3'b110 gives an `op_err` pulse, `busy` stays 0 and `err_cnt` is unchanged. A second `start` mid-sweep is ignored: latency and the `stim` sequence are unchanged.
- `rst` pulsed after 3 vectors:
  - All outputs return to reset values immediately, with no `done` pulse.
  - A restart completes a full 4-vector sweep with correct counts.

Source files
------------

// File: rtl/gate_sweep_if.sv
// Signal bundle between gate_sweep (slave) and the harness that hosts the gate under test (master).
interface gate_sweep_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
);
  logic             start;
  logic [2:0]       op;
  logic             dut_op;
  logic [N_IN-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic             op_err;
  logic [N_IN-1:0]  first_fail;
  logic             fail_valid;

  modport master (
    output start, op, dut_op,
    input  stim, busy, done, pass, err_cnt, op_err, first_fail, fail_valid
  );

  modport slave (
    input  start, op, dut_op,
    output stim, busy, done, pass, err_cnt, op_err, first_fail, fail_valid
  );
endinterface

// File: rtl/gate_sweep.sv
// Exhaustive truth-table checker: sweeps every input vector, compares the gate response to a reference.
// Optional first-failure capture is enabled by defining GATE_SWEEP_FAIL_CAPTURE_EN.
module gate_sweep #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input logic        clk,
  input logic        rst,
  gate_sweep_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE > 0 ? SETTLE - 1 : 0);

  state_t           state, state_next;
  logic [2:0]       op_q;
  logic [3:0]       settle_cnt;
  logic [N_IN-1:0]  stim;
  logic [CNT_W-1:0] err_cnt, err_next;
  logic             pass, op_err;
  logic             busy, done;
  logic             start_ok, start_bad, ref_bit, mismatch, last_vec, settle_end;

  assign start_ok   = (state == S_IDLE) && bus.start && (bus.op < 3'd6);
  assign start_bad  = (state == S_IDLE) && bus.start && (bus.op >= 3'd6);
  assign last_vec   = &stim;
  assign settle_end = (settle_cnt == SETTLE_LAST);

  always_comb begin
    ref_bit = 1'b0;
    case (op_q)
      3'd0:    ref_bit = &stim;
      3'd1:    ref_bit = |stim;
      3'd2:    ref_bit = ^stim;
      3'd3:    ref_bit = ~&stim;
      3'd4:    ref_bit = ~|stim;
      3'd5:    ref_bit = ~^stim;
      default: ref_bit = 1'b0;
    endcase
  end

  assign mismatch = (state == S_CHECK) && (bus.dut_op != ref_bit);
  assign err_next = (mismatch && !(&err_cnt)) ? err_cnt + CNT_W'(1) : err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_next = (SETTLE == 0) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_end) state_next = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (last_vec)         state_next = S_DONE;
        else if (SETTLE != 0) state_next = S_SETTLE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // pass is resolved on the final CHECK edge so it is already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 3'd0;
      settle_cnt <= 4'd0;
      stim       <= '0;
      err_cnt    <= '0;
      pass       <= 1'b0;
      op_err     <= 1'b0;
    end else begin
      op_err <= start_bad;
      if (start_ok) begin
        op_q       <= bus.op;
        stim       <= '0;
        err_cnt    <= '0;
        pass       <= 1'b0;
        settle_cnt <= 4'd0;
      end
      if (state == S_SETTLE) settle_cnt <= settle_end ? 4'd0 : settle_cnt + 4'd1;
      if (state == S_CHECK) begin
        err_cnt <= err_next;
        if (last_vec) pass <= (err_next == '0);
        else          stim <= stim + N_IN'(1);
      end
    end
  end

`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
  logic [N_IN-1:0] first_fail;
  logic            fail_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else if (start_ok) begin
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else if (mismatch && !fail_valid) begin
      first_fail <= stim;
      fail_valid <= 1'b1;
    end
  end

  assign bus.first_fail = first_fail;
  assign bus.fail_valid = fail_valid;
`else
  assign bus.first_fail = '0;
  assign bus.fail_valid = 1'b0;
`endif

  assign bus.stim    = stim;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.pass    = pass;
  assign bus.err_cnt = err_cnt;
  assign bus.op_err  = op_err;
endmodule
